// File: rtl/mem_wb_ctrl.sv
// MEM/WB boundary and data-memory sequencer: issues one request per access,
// stalls the pipe while it is outstanding and registers the writeback result.
module mem_wb_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [15:0]      alu_result,
    input  logic [15:0]      write_data,
    input  logic             reg_write_in,
    input  logic             mem_to_reg_in,
    input  logic [2:0]       write_reg_in,
    input  logic             halt_in,
    input  logic [15:0]      read_data,
    input  logic             done,
    input  logic             stall_from_mem,
    input  logic             cache_hit,
    input  logic             mem_err,
    output logic [15:0]      mem_addr,
    output logic [15:0]      mem_din,
    output logic             mem_req_rd,
    output logic             mem_req_wr,
    output logic             stall_pipe,
    output logic             wb_valid,
    output logic             wb_reg_write,
    output logic [2:0]       wb_write_reg,
    output logic [15:0]      wb_data,
    output logic             wb_halt,
    output logic             wb_err,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] hit_cnt
);

    localparam int TO_W = $clog2(TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_r;
    logic [TO_W-1:0]   to_cnt_r;
    logic              wb_valid_r;
    logic              wb_reg_write_r;
    logic [2:0]        wb_write_reg_r;
    logic [15:0]       wb_data_r;
    logic              wb_halt_r;
    logic              wb_err_r;
    logic [CNT_W-1:0]  access_cnt_r;
    logic [CNT_W-1:0]  hit_cnt_r;

    logic              acc_s;
    logic              issue_s;
    logic              stall_s;
    logic              done_acc_s;
    logic              err_s;
    logic              cap_s;
    logic [15:0]       cap_data_s;

    // Per-cycle decision: request issue, pipe stall, WB capture or error.
    always_comb begin
        acc_s      = mem_valid & (mem_rd | mem_wr);
        issue_s    = 1'b0;
        stall_s    = 1'b0;
        done_acc_s = 1'b0;
        err_s      = 1'b0;
        cap_s      = 1'b0;
        cap_data_s = alu_result;
        if (!rst) begin
            issue_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    err_s = mem_err;
                    if (mem_valid && halt_in) begin
                        cap_s = 1'b1;
                    end else if (acc_s) begin
                        if (stall_from_mem) begin
                            stall_s = 1'b1;
                        end else begin
                            issue_s    = 1'b1;
                            done_acc_s = done;
                            cap_s      = done;
                            stall_s    = ~done;
                            cap_data_s = mem_to_reg_in ? read_data : alu_result;
                        end
                    end else begin
                        cap_s = mem_valid;
                    end
                end
                ST_WAIT: begin
                    // done in the last allowed cycle still wins over the timeout
                    err_s      = mem_err | (~done & (to_cnt_r == TO_LAST));
                    done_acc_s = done;
                    cap_s      = done;
                    stall_s    = ~done;
                    cap_data_s = mem_to_reg_in ? read_data : alu_result;
                end
                ST_HALT: begin
                    stall_s = 1'b1;
                end
                default: begin
                    stall_s = 1'b1;
                end
            endcase
        end
    end

    assign mem_req_wr = issue_s & mem_wr;
    assign mem_req_rd = issue_s & mem_rd & ~mem_wr;
    assign mem_addr   = rst ? alu_result : 16'h0000;
    assign mem_din    = rst ? write_data : 16'h0000;
    assign stall_pipe = stall_s;

    // Sequencer state, writeback register set and performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= ST_IDLE;
            to_cnt_r       <= {TO_W{1'b0}};
            wb_valid_r     <= 1'b0;
            wb_reg_write_r <= 1'b0;
            wb_write_reg_r <= 3'd0;
            wb_data_r      <= 16'h0000;
            wb_halt_r      <= 1'b0;
            wb_err_r       <= 1'b0;
            access_cnt_r   <= {CNT_W{1'b0}};
            hit_cnt_r      <= {CNT_W{1'b0}};
        end else begin
            if (err_s) begin
                wb_valid_r     <= 1'b1;
                wb_reg_write_r <= 1'b0;
                wb_halt_r      <= 1'b1;
                wb_err_r       <= 1'b1;
            end else if (cap_s) begin
                wb_valid_r     <= 1'b1;
                wb_reg_write_r <= reg_write_in;
                wb_write_reg_r <= write_reg_in;
                wb_data_r      <= cap_data_s;
                wb_halt_r      <= wb_halt_r | halt_in;
            end else begin
                wb_valid_r     <= 1'b0;
                wb_reg_write_r <= 1'b0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (err_s || (mem_valid && halt_in)) begin
                        state_r <= ST_HALT;
                    end else if (issue_s && !done) begin
                        state_r  <= ST_WAIT;
                        to_cnt_r <= {TO_W{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (err_s) begin
                        state_r <= ST_HALT;
                    end else if (done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r  <= ST_WAIT;
                        to_cnt_r <= to_cnt_r + TO_W'(1);
                    end
                end
                ST_HALT: begin
                    state_r  <= ST_HALT;
                    wb_err_r <= wb_err_r | mem_err;
                end
                default: begin
                    state_r <= ST_HALT;
                end
            endcase

            if (done_acc_s && (access_cnt_r != CNT_MAX)) begin
                access_cnt_r <= access_cnt_r + CNT_W'(1);
            end else begin
                access_cnt_r <= access_cnt_r;
            end
            if (done_acc_s && cache_hit && (hit_cnt_r != CNT_MAX)) begin
                hit_cnt_r <= hit_cnt_r + CNT_W'(1);
            end else begin
                hit_cnt_r <= hit_cnt_r;
            end
        end
    end

    assign wb_valid     = wb_valid_r;
    assign wb_reg_write = wb_reg_write_r;
    assign wb_write_reg = wb_write_reg_r;
    assign wb_data      = wb_data_r;
    assign wb_halt      = wb_halt_r;
    assign wb_err       = wb_err_r;
    assign access_cnt   = access_cnt_r;
    assign hit_cnt      = hit_cnt_r;

endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed bench for mem_wb_ctrl with TIMEOUT=8 and 4-bit counters.
module tb_mem_wb_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] alu_result;
    logic [15:0] write_data;
    logic        reg_write_in;
    logic        mem_to_reg_in;
    logic [2:0]  write_reg_in;
    logic        halt_in;
    logic [15:0] read_data;
    logic        done;
    logic        stall_from_mem;
    logic        cache_hit;
    logic        mem_err;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_req_rd;
    logic        mem_req_wr;
    logic        stall_pipe;
    logic        wb_valid;
    logic        wb_reg_write;
    logic [2:0]  wb_write_reg;
    logic [15:0] wb_data;
    logic        wb_halt;
    logic        wb_err;
    logic [3:0]  access_cnt;
    logic [3:0]  hit_cnt;

    int errors = 0;
    int checks = 0;

    mem_wb_ctrl #(.TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .alu_result(alu_result), .write_data(write_data), .reg_write_in(reg_write_in),
        .mem_to_reg_in(mem_to_reg_in), .write_reg_in(write_reg_in), .halt_in(halt_in),
        .read_data(read_data), .done(done), .stall_from_mem(stall_from_mem),
        .cache_hit(cache_hit), .mem_err(mem_err), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_req_rd(mem_req_rd), .mem_req_wr(mem_req_wr), .stall_pipe(stall_pipe),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
        .wb_data(wb_data), .wb_halt(wb_halt), .wb_err(wb_err),
        .access_cnt(access_cnt), .hit_cnt(hit_cnt)
    );

    // Free-running core clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        alu_result = 16'h0000; write_data = 16'h0000;
        reg_write_in = 1'b0; mem_to_reg_in = 1'b0; write_reg_in = 3'd0; halt_in = 1'b0;
        read_data = 16'h0000; done = 1'b0; stall_from_mem = 1'b0;
        cache_hit = 1'b0; mem_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        mem_valid = 1'b1; mem_rd = 1'b1; alu_result = 16'h55AA; write_data = 16'h1111;
        @(negedge clk);
        #1;
        checks++; if (mem_req_rd !== 1'b0) begin errors++; $display("FAIL reset_req_rd got %b want 0", mem_req_rd); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", mem_addr); end
        checks++; if (mem_din !== 16'h0000) begin errors++; $display("FAIL reset_din got %h want 0000", mem_din); end
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_pipe); end
        checks++; if ({wb_valid, wb_halt, wb_err, access_cnt, hit_cnt} !== 11'd0) begin
            errors++; $display("FAIL reset_regs got %b/%b/%b/%h/%h want all 0", wb_valid, wb_halt, wb_err, access_cnt, hit_cnt);
        end
    endtask

    task automatic test_zero_wait_load();
        do_reset();
        mem_valid = 1'b1; mem_rd = 1'b1; alu_result = 16'h0040; read_data = 16'hBEEF;
        mem_to_reg_in = 1'b1; reg_write_in = 1'b1; write_reg_in = 3'd3; done = 1'b1; cache_hit = 1'b1;
        #1;
        checks++; if (mem_req_rd !== 1'b1) begin errors++; $display("FAIL zw_req_rd got %b want 1", mem_req_rd); end
        checks++; if (mem_req_wr !== 1'b0) begin errors++; $display("FAIL zw_req_wr got %b want 0", mem_req_wr); end
        checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL zw_stall got %b want 0", stall_pipe); end
        checks++; if (mem_addr !== 16'h0040) begin errors++; $display("FAIL zw_addr got %h want 0040", mem_addr); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL zw_wb_valid got %b want 1", wb_valid); end
        checks++; if (wb_data !== 16'hBEEF) begin errors++; $display("FAIL zw_wb_data got %h want beef", wb_data); end
        checks++; if (wb_write_reg !== 3'd3) begin errors++; $display("FAIL zw_wb_reg got %0d want 3", wb_write_reg); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL zw_wb_rw got %b want 1", wb_reg_write); end
        checks++; if (hit_cnt !== 4'd1) begin errors++; $display("FAIL zw_hit_cnt got %0d want 1", hit_cnt); end
        checks++; if (access_cnt !== 4'd1) begin errors++; $display("FAIL zw_acc_cnt got %0d want 1", access_cnt); end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (mem_req_rd !== 1'b0) begin errors++; $display("FAIL zw_req_drop got %b want 0", mem_req_rd); end
        @(posedge clk); #1;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL zw_bubble got %b want 0", wb_valid); end
    endtask

    task automatic test_store_miss();
        int req_cycles = 0;
        int stall_cycles = 0;
        do_reset();
        mem_valid = 1'b1; mem_wr = 1'b1; alu_result = 16'h0100; write_data = 16'hCAFE;
        for (int c = 0; c < 5; c++) begin
            done = (c == 4);
            #1;
            if (c == 0) begin
                checks++; if (mem_din !== 16'hCAFE) begin errors++; $display("FAIL sm_din got %h want cafe", mem_din); end
            end
            if (mem_req_wr === 1'b1) req_cycles++;
            if (stall_pipe === 1'b1) stall_cycles++;
            @(posedge clk); #1;
            checks++; if (wb_valid !== (c == 4)) begin errors++; $display("FAIL sm_wb_valid c=%0d got %b want %b", c, wb_valid, (c == 4)); end
            @(negedge clk);
        end
        checks++; if (req_cycles != 1) begin errors++; $display("FAIL sm_req_cycles got %0d want 1", req_cycles); end
        checks++; if (stall_cycles != 4) begin errors++; $display("FAIL sm_stall_cycles got %0d want 4", stall_cycles); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL sm_wb_rw got %b want 0", wb_reg_write); end
        checks++; if (access_cnt !== 4'd1) begin errors++; $display("FAIL sm_acc_cnt got %0d want 1", access_cnt); end
        checks++; if (hit_cnt !== 4'd0) begin errors++; $display("FAIL sm_hit_cnt got %0d want 0", hit_cnt); end
        idle_inputs();
    endtask

    task automatic test_mem_stall();
        do_reset();
        mem_valid = 1'b1; mem_rd = 1'b1; alu_result = 16'h0200; mem_to_reg_in = 1'b1;
        reg_write_in = 1'b1; write_reg_in = 3'd5;
        for (int c = 0; c < 5; c++) begin
            stall_from_mem = (c < 2);
            done = (c == 4);
            read_data = (c == 4) ? 16'h1357 : 16'hDEAD;
            #1;
            checks++; if (mem_req_rd !== (c == 2)) begin errors++; $display("FAIL ms_req c=%0d got %b want %b", c, mem_req_rd, (c == 2)); end
            checks++; if (stall_pipe !== (c != 4)) begin errors++; $display("FAIL ms_stall c=%0d got %b want %b", c, stall_pipe, (c != 4)); end
            @(negedge clk);
        end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL ms_wb_valid got %b want 1", wb_valid); end
        checks++; if (wb_data !== 16'h1357) begin errors++; $display("FAIL ms_wb_data got %h want 1357", wb_data); end
        checks++; if (wb_write_reg !== 3'd5) begin errors++; $display("FAIL ms_wb_reg got %0d want 5", wb_write_reg); end
        idle_inputs();
    endtask

    task automatic test_timeout();
        int req_cycles = 0;
        do_reset();
        mem_valid = 1'b1; mem_rd = 1'b1; alu_result = 16'h0300; reg_write_in = 1'b1;
        for (int c = 0; c < 11; c++) begin
            #1;
            if (mem_req_rd === 1'b1) req_cycles++;
            if (c >= 9) begin
                checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL to_halt_stall c=%0d got %b want 1", c, stall_pipe); end
            end
            @(posedge clk); #1;
            if (c == 7) begin
                checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL to_early got %b want 0", wb_err); end
            end
            if (c == 8) begin
                checks++; if ({wb_err, wb_halt, wb_valid, wb_reg_write} !== 4'b1110) begin
                    errors++; $display("FAIL to_err got %b want 1110", {wb_err, wb_halt, wb_valid, wb_reg_write});
                end
            end
            if (c == 9) begin
                checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL to_halt_valid got %b want 0", wb_valid); end
            end
            @(negedge clk);
        end
        checks++; if (req_cycles != 1) begin errors++; $display("FAIL to_req_cycles got %0d want 1", req_cycles); end
        idle_inputs();
    endtask

    task automatic test_mem_err();
        do_reset();
        mem_valid = 1'b1; mem_wr = 1'b1; reg_write_in = 1'b1; mem_err = 1'b1;
        @(posedge clk); #1;
        checks++; if ({wb_err, wb_halt, wb_valid, wb_reg_write} !== 4'b1110) begin
            errors++; $display("FAIL me_err got %b want 1110", {wb_err, wb_halt, wb_valid, wb_reg_write});
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL me_halt_stall got %b want 1", stall_pipe); end
    endtask

    task automatic test_alu_halt();
        do_reset();
        mem_valid = 1'b1; alu_result = 16'h1234; reg_write_in = 1'b1; write_reg_in = 3'd2;
        #1;
        checks++; if ({stall_pipe, mem_req_rd, mem_req_wr} !== 3'b000) begin
            errors++; $display("FAIL alu_ctrl got %b want 000", {stall_pipe, mem_req_rd, mem_req_wr});
        end
        @(posedge clk); #1;
        checks++; if (wb_data !== 16'h1234) begin errors++; $display("FAIL alu_wb_data got %h want 1234", wb_data); end
        checks++; if ({wb_valid, wb_reg_write, wb_halt} !== 3'b110) begin
            errors++; $display("FAIL alu_wb_flags got %b want 110", {wb_valid, wb_reg_write, wb_halt});
        end
        @(negedge clk);
        halt_in = 1'b1; reg_write_in = 1'b0; alu_result = 16'h0000;
        @(posedge clk); #1;
        checks++; if ({wb_halt, wb_valid, wb_err} !== 3'b110) begin
            errors++; $display("FAIL halt_capture got %b want 110", {wb_halt, wb_valid, wb_err});
        end
        @(negedge clk);
        idle_inputs();
        alu_result = 16'hFFFF;
        #1;
        checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL halt_stall got %b want 1", stall_pipe); end
        @(posedge clk); #1;
        checks++; if ({wb_valid, wb_halt} !== 2'b01) begin errors++; $display("FAIL halt_hold got %b want 01", {wb_valid, wb_halt}); end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++; if ({wb_halt, wb_valid, stall_pipe, wb_data, mem_addr} !== 35'd0) begin
            errors++; $display("FAIL halt_reset got %b/%b/%b/%h/%h want all 0", wb_halt, wb_valid, stall_pipe, wb_data, mem_addr);
        end
    endtask

    task automatic test_hit_saturate();
        do_reset();
        mem_valid = 1'b1; mem_rd = 1'b1; done = 1'b1; cache_hit = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #1;
            checks++; if (hit_cnt !== ((i < 15) ? 4'(i + 1) : 4'hF)) begin
                errors++; $display("FAIL sat_hit i=%0d got %0d want %0d", i, hit_cnt, (i < 15) ? i + 1 : 15);
            end
            @(negedge clk);
        end
        checks++; if (access_cnt !== 4'hF) begin errors++; $display("FAIL sat_acc got %0d want 15", access_cnt); end
        idle_inputs();
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_zero_wait_load();
        test_store_miss();
        test_mem_stall();
        test_timeout();
        test_mem_err();
        test_alu_halt();
        test_hit_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_ctrl.md
Name: mem_wb_ctrl

Overview:
MEM/WB pipeline boundary and data-memory sequencer for the five-stage 16-bit core.
- Takes the instruction leaving the memory stage and issues exactly one Rd/Wr request per access to the stalling data memory.
- While that access is outstanding, it stalls the upstream pipeline and sends bubbles into writeback.
- When the memory reports done, it captures the result into the writeback register set. Memory errors and halt are made sticky.

Parameters:
TIMEOUT, 64, max cycles in WAIT without done before a memory error is forced (must be >= 2).
CNT_W, 16, width of the saturating access and hit performance counters.

Ports:
clk  input  1  core clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
mem_valid  input  1  valid instruction present in MEM stage
mem_rd  input  1  instruction is a load
mem_wr  input  1  instruction is a store (mem_rd and mem_wr both high is treated as store)
alu_result  input  16  address / ALU result from EX/MEM
write_data  input  16  store data from EX/MEM
reg_write_in  input  1  instruction writes register file
mem_to_reg_in  input  1  writeback selects memory data
write_reg_in  input  3  destination register
halt_in  input  1  instruction is HALT
read_data  input  16  data memory DataOut
done  input  1  data memory Done (one-cycle pulse)
stall_from_mem  input  1  data memory Stall
cache_hit  input  1  data memory CacheHit, qualified by done
mem_err  input  1  data memory err
mem_addr  output  16  request address (= alu_result)
mem_din  output  16  request data (= write_data)
mem_req_rd  output  1  Rd request to data memory
mem_req_wr  output  1  Wr request to data memory
stall_pipe  output  1  hold PC, IF/ID, ID/EX, EX/MEM
wb_valid  output  1  writeback register holds a real instruction
wb_reg_write  output  1  registered reg_write
wb_write_reg  output  3  registered destination
wb_data  output  16  registered result (read_data if mem_to_reg, else alu_result)
wb_halt  output  1  sticky halt/error to writeback and createdump
wb_err  output  1  sticky memory error flag
access_cnt  output  CNT_W  completed memory accesses, saturating
hit_cnt  output  CNT_W  completed accesses with cache_hit, saturating

Behaviour:
- Reset (rst low, async):
  - State returns to IDLE.
  - All registered outputs clear to 0: wb_*, counters, timeout counter.
  - Combinational outputs are forced low during reset.
- Definitions:
  - acc = mem_valid & (mem_rd | mem_wr).
  - mem_req_wr = mem_wr; mem_req_rd = mem_rd & !mem_wr.
  - mem_addr/mem_din are pass-through.
- IDLE:
  - If acc and !stall_from_mem: assert the selected req for exactly this cycle.
    - If done is also high this cycle (zero-wait hit): capture into WB at the edge, stall_pipe = 0, stay IDLE.
    - Otherwise stall_pipe = 1 and go to WAIT.
  - If acc and stall_from_mem: no req, stall_pipe = 1, WB gets a bubble, stay IDLE and retry the next cycle.
  - If mem_valid & !acc: capture into WB (wb_data = alu_result), stall_pipe = 0.
  - If !mem_valid: WB gets a bubble (wb_valid = 0, wb_reg_write = 0).
- WAIT:
  - req low and stall_pipe = 1 until done; WB gets a bubble each cycle.
  - On done: capture into WB using the read_data present in that cycle, stall_pipe = 0 in that cycle, return to IDLE.
  - Timeout counter clears on entering WAIT and increments each WAIT cycle. When it reaches TIMEOUT-1 without done, treat as mem_err.
- Error (mem_err in any state, or timeout):
  - Set wb_err and wb_halt.
  - Capture wb_valid = 1 with wb_reg_write = 0.
  - Go to HALT.
- HALT:
  - stall_pipe = 1, no requests, wb_valid = 0 after the first cycle.
  - Leaves only on reset.
- halt_in with mem_valid in IDLE: capture as a normal non-access instruction, set wb_halt, go to HALT.
- Capture into WB means:
  - wb_valid = 1, wb_reg_write = reg_write_in, wb_write_reg = write_reg_in, wb_halt = halt_in.
  - wb_data = mem_to_reg_in ? read_data : alu_result.
- Counters:
  - access_cnt increments on each done.
  - hit_cnt increments on done & cache_hit.
  - Both saturate at all-ones and never wrap.
- Reset asserted mid-WAIT: the access is abandoned and no WB capture occurs. The memory is reset by the same rst.

Test Plan:
- Load with done and cache_hit in the request cycle, alu_result=0x0040, read_data=0xBEEF, mem_to_reg=1, write_reg=3 -> mem_req_rd=1 for 1 cycle, stall_pipe never high, next cycle wb_valid=1, wb_data=0xBEEF, wb_write_reg=3, hit_cnt=1.
- Store miss, done 4 cycles after request -> mem_req_wr high 1 cycle only, stall_pipe high 4 cycles, wb_valid=0 during wait, then 1 with wb_reg_write=0; access_cnt=1, hit_cnt=0.
- stall_from_mem high 2 cycles when load arrives -> no request for 2 cycles, request on 3rd, stall_pipe continuous until done.
- TIMEOUT=8, done never returned -> after 8 WAIT cycles wb_err=1, wb_halt=1, stall_pipe stays 1, no further requests.
- ALU op (mem_valid=1, no access, alu_result=0x1234) followed by halt_in -> wb_data=0x1234 then wb_halt=1, HALT entered; drive rst low mid-HALT -> all outputs 0 immediately.
- Force hit_cnt via 2^CNT_W hits (CNT_W=4: 16 hits) -> hit_cnt holds 0xF.
